// File: rtl/spi_block_dma.sv
// SD block mover between the SPI byte engine and RAM, covering the token, CRC and response/busy handshakes.
// Define SPI_BLOCK_DMA_CRC_EN to generate and check CRC16-CCITT over the data bytes.
module spi_block_dma #(
   parameter int ADDR_WIDTH    = 16,
   parameter int BLOCK_BYTES   = 512,
   parameter int NBLK_WIDTH    = 4,
   parameter int TOKEN_TIMEOUT = 4096,
   parameter int BUSY_TIMEOUT  = 65535
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  start,
   input  logic                  write_mode,
   input  logic [ADDR_WIDTH-1:0] iaddr,
   input  logic [NBLK_WIDTH-1:0] nblocks,
   output logic                  ready,
   output logic                  error,
   output logic [NBLK_WIDTH-1:0] blocks_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   output logic                  mem_wr,
   output logic                  mem_rd,
   input  logic [7:0]            mem_rdata,
   output logic [7:0]            spi_do,
   output logic                  spi_wr,
   input  logic [7:0]            spi_di,
   input  logic                  spi_busy
);

   localparam int BC_W     = $clog2(BLOCK_BYTES);
   localparam int POLL_MAX = (TOKEN_TIMEOUT > BUSY_TIMEOUT) ? TOKEN_TIMEOUT : BUSY_TIMEOUT;
   localparam int POLL_W   = $clog2(POLL_MAX + 2);
   localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BLOCK_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_RDWAIT, S_RDCAP, S_XIGN, S_XWAIT, S_WRMEM
   } state_t;

   typedef enum logic [2:0] {
      P_TOKEN, P_DATA, P_CRC, P_RESP, P_BUSY
   } phase_t;

   state_t                state_q, state_d;
   phase_t                phase_q, phase_d;
   logic                  mode_q, mode_d;
   logic [NBLK_WIDTH-1:0] nblk_q, nblk_d;
   logic [NBLK_WIDTH-1:0] blocks_done_q, blocks_done_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]            wdata_q, wdata_d;
   logic                  mem_wr_q, mem_wr_d;
   logic                  mem_rd_q, mem_rd_d;
   logic [7:0]            spi_do_q, spi_do_d;
   logic                  spi_wr_q, spi_wr_d;
   logic                  ready_q, ready_d;
   logic                  error_q, error_d;
   logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
   logic [POLL_W-1:0]     poll_q, poll_d;
   logic [POLL_W-1:0]     poll_next;
   logic                  fail;
   logic                  blk_done;

`ifdef SPI_BLOCK_DMA_CRC_EN
   logic [15:0] crc_q, crc_d;
   logic        crc_bad_q, crc_bad_d;

   function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc_q     <= 16'h0000;
         crc_bad_q <= 1'b0;
      end else if (ce) begin
         crc_q     <= crc_d;
         crc_bad_q <= crc_bad_d;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         phase_q       <= P_TOKEN;
         mode_q        <= 1'b0;
         nblk_q        <= '0;
         blocks_done_q <= '0;
         addr_q        <= '0;
         wdata_q       <= 8'h00;
         mem_wr_q      <= 1'b0;
         mem_rd_q      <= 1'b0;
         spi_do_q      <= 8'hFF;
         spi_wr_q      <= 1'b0;
         ready_q       <= 1'b1;
         error_q       <= 1'b0;
         byte_cnt_q    <= '0;
         poll_q        <= '0;
      end else if (ce) begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         mode_q        <= mode_d;
         nblk_q        <= nblk_d;
         blocks_done_q <= blocks_done_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         mem_wr_q      <= mem_wr_d;
         mem_rd_q      <= mem_rd_d;
         spi_do_q      <= spi_do_d;
         spi_wr_q      <= spi_wr_d;
         ready_q       <= ready_d;
         error_q       <= error_d;
         byte_cnt_q    <= byte_cnt_d;
         poll_q        <= poll_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      mode_d        = mode_q;
      nblk_d        = nblk_q;
      blocks_done_d = blocks_done_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      mem_wr_d      = 1'b0;
      mem_rd_d      = 1'b0;
      spi_do_d      = spi_do_q;
      spi_wr_d      = 1'b0;
      ready_d       = ready_q;
      error_d       = error_q;
      byte_cnt_d    = byte_cnt_q;
      poll_d        = poll_q;
      poll_next     = poll_q + POLL_W'(1);
      fail          = 1'b0;
      blk_done      = 1'b0;
`ifdef SPI_BLOCK_DMA_CRC_EN
      crc_d         = crc_q;
      crc_bad_d     = crc_bad_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start && nblocks != '0) begin
               mode_d        = write_mode;
               addr_d        = iaddr;
               nblk_d        = nblocks;
               error_d       = 1'b0;
               blocks_done_d = '0;
               ready_d       = 1'b0;
               phase_d       = P_TOKEN;
               poll_d        = '0;
               byte_cnt_d    = '0;
`ifdef SPI_BLOCK_DMA_CRC_EN
               crc_d         = 16'h0000;
               crc_bad_d     = 1'b0;
`endif
               state_d       = S_PREP;
            end
         end
         S_PREP: begin
            if (phase_q == P_DATA && mode_q) begin
               mem_rd_d = 1'b1;
               state_d  = S_RDWAIT;
            end else begin
               spi_wr_d = 1'b1;
               spi_do_d = (phase_q == P_TOKEN && mode_q) ? 8'hFE : 8'hFF;
`ifdef SPI_BLOCK_DMA_CRC_EN
               if (phase_q == P_CRC && mode_q)
                  spi_do_d = (byte_cnt_q == '0) ? crc_q[15:8] : crc_q[7:0];
`endif
               state_d  = S_XIGN;
            end
         end
         // RAM samples mem_rd on this edge; its data is usable one ce cycle later.
         S_RDWAIT: state_d = S_RDCAP;
         S_RDCAP: begin
            spi_do_d = mem_rdata;
            spi_wr_d = 1'b1;
`ifdef SPI_BLOCK_DMA_CRC_EN
            crc_d    = crc16_upd(crc_q, mem_rdata);
`endif
            state_d  = S_XIGN;
         end
         // The SPI engine has not raised busy yet on the cycle right after the strobe.
         S_XIGN: state_d = S_XWAIT;
         S_XWAIT: begin
            if (!spi_busy) begin
               state_d = S_PREP;
               case (phase_q)
                  P_TOKEN: begin
                     if (mode_q || spi_di == 8'hFE) begin
                        phase_d    = P_DATA;
                        byte_cnt_d = '0;
                     end else if (spi_di == 8'hFF && poll_next != POLL_W'(TOKEN_TIMEOUT)) begin
                        poll_d = poll_next;
                     end else begin
                        fail = 1'b1;
                     end
                  end
                  P_DATA: begin
                     if (mode_q) begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        if (byte_cnt_q == LAST_BYTE) begin
                           phase_d    = P_CRC;
                           byte_cnt_d = '0;
                        end else begin
                           byte_cnt_d = byte_cnt_q + BC_W'(1);
                        end
                     end else begin
                        mem_wr_d = 1'b1;
                        wdata_d  = spi_di;
`ifdef SPI_BLOCK_DMA_CRC_EN
                        crc_d    = crc16_upd(crc_q, spi_di);
`endif
                        state_d  = S_WRMEM;
                     end
                  end
                  P_CRC: begin
`ifdef SPI_BLOCK_DMA_CRC_EN
                     if (!mode_q && spi_di != ((byte_cnt_q == '0) ? crc_q[15:8] : crc_q[7:0]))
                        crc_bad_d = 1'b1;
`endif
                     if (byte_cnt_q == '0) begin
                        byte_cnt_d = BC_W'(1);
                     end else if (mode_q) begin
                        phase_d = P_RESP;
                     end else begin
                        blk_done = 1'b1;
`ifdef SPI_BLOCK_DMA_CRC_EN
                        if (crc_bad_d) begin
                           blk_done = 1'b0;
                           fail     = 1'b1;
                        end
`endif
                     end
                  end
                  P_RESP: begin
                     if ((spi_di & 8'h1F) == 8'h05) begin
                        phase_d = P_BUSY;
                        poll_d  = '0;
                     end else begin
                        fail = 1'b1;
                     end
                  end
                  P_BUSY: begin
                     if (spi_di != 8'h00)                     blk_done = 1'b1;
                     else if (poll_next > POLL_W'(BUSY_TIMEOUT)) fail     = 1'b1;
                     else                                     poll_d   = poll_next;
                  end
                  default: fail = 1'b1;
               endcase
            end
         end
         S_WRMEM: begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = S_PREP;
            if (byte_cnt_q == LAST_BYTE) begin
               phase_d    = P_CRC;
               byte_cnt_d = '0;
            end else begin
               byte_cnt_d = byte_cnt_q + BC_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (blk_done) begin
         blocks_done_d = blocks_done_q + NBLK_WIDTH'(1);
         if (blocks_done_d == nblk_q) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end else begin
            phase_d    = P_TOKEN;
            poll_d     = '0;
            byte_cnt_d = '0;
`ifdef SPI_BLOCK_DMA_CRC_EN
            crc_d      = 16'h0000;
            crc_bad_d  = 1'b0;
`endif
         end
      end
      if (fail) begin
         state_d = S_IDLE;
         ready_d = 1'b1;
         error_d = 1'b1;
      end
   end

   assign ready       = ready_q;
   assign error       = error_q;
   assign blocks_done = blocks_done_q;
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign spi_do      = spi_do_q;
   assign mem_wr      = mem_wr_q & ce;
   assign mem_rd      = mem_rd_q & ce;
   assign spi_wr      = spi_wr_q & ce;

endmodule

// File: tb/tb_spi_block_dma.sv
// Randomised bench for spi_block_dma: an SD-card/SPI responder and RAM model, checked against
// expected byte streams built from the block protocol rules (CRC cases when SPI_BLOCK_DMA_CRC_EN is set).
module tb_spi_block_dma;

   localparam int BB = 512;

   logic        clk = 1'b0;
   logic        reset, ce, start, write_mode;
   logic [15:0] iaddr;
   logic [3:0]  nblocks;
   logic        ready, error;
   logic [3:0]  blocks_done;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata, spi_do, spi_di;
   logic        mem_wr, mem_rd, spi_wr, spi_busy;

   spi_block_dma #(
      .ADDR_WIDTH(16), .BLOCK_BYTES(BB), .NBLK_WIDTH(4),
      .TOKEN_TIMEOUT(4096), .BUSY_TIMEOUT(65535)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce), .start(start), .write_mode(write_mode),
      .iaddr(iaddr), .nblocks(nblocks), .ready(ready), .error(error),
      .blocks_done(blocks_done), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .spi_do(spi_do),
      .spi_wr(spi_wr), .spi_di(spi_di), .spi_busy(spi_busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // card / RAM environment state
   logic [7:0]  ram [0:65535];
   logic [7:0]  rsp_q[$];
   logic [7:0]  tx_log[$];
   logic [15:0] wa_log[$];
   logic [7:0]  wd_log[$];
   logic [15:0] ra_log[$];
   int          viol;
   bit          ce_rand;
   int          busy_max;
   bit          pend;
   int          busy_left;
   logic [7:0]  pend_rx;

   // expectations
   logic [7:0]  exp_tx[$];
   logic [15:0] exp_wa[$];
   logic [7:0]  exp_wd[$];
   logic [15:0] exp_ra[$];

   function automatic logic [15:0] crc16(input logic [15:0] crc_in, input logic [7:0] d);
      logic [15:0] c;
      c = crc_in ^ {d, 8'h00};
      for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction

   initial begin
      logic s_ce, s_sw, s_mw, s_mr;
      logic [7:0]  s_do, s_wd;
      logic [15:0] s_a;
      spi_busy = 1'b0; spi_di = 8'hFF; mem_rdata = 8'h00; ce = 1'b1;
      pend = 1'b0; busy_left = 0; viol = 0;
      forever begin
         @(negedge clk);
         s_ce = ce; s_sw = spi_wr; s_mw = mem_wr; s_mr = mem_rd;
         s_do = spi_do; s_wd = mem_wdata; s_a = mem_addr;
         if (s_mw && s_mr) viol++;
         if (!s_ce && (s_sw || s_mw || s_mr)) viol++;
         if (s_sw && pend) viol++;
         @(posedge clk);
         #1;
         if (reset) begin
            pend = 1'b0;
            spi_busy = 1'b0;
         end else if (s_ce) begin
            if (s_mw) begin
               ram[s_a] = s_wd;
               wa_log.push_back(s_a);
               wd_log.push_back(s_wd);
            end
            if (s_mr) begin
               mem_rdata = ram[s_a];
               ra_log.push_back(s_a);
            end
            if (pend) begin
               if (busy_left == 0) begin
                  spi_busy = 1'b0;
                  spi_di = pend_rx;
                  pend = 1'b0;
               end else begin
                  busy_left--;
               end
            end
            if (s_sw) begin
               tx_log.push_back(s_do);
               pend_rx = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'hFF;
               pend = 1'b1;
               spi_busy = 1'b1;
               busy_left = $urandom_range(0, busy_max);
            end
         end
         ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   task automatic clear_exp();
      exp_tx.delete(); exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); rsp_q.delete();
   endtask

   task automatic add_read_block(input logic [15:0] base, input int pat, input int npre,
                                 input bit crc_force, input logic [15:0] crc_val);
      logic [7:0]  d;
      logic [15:0] crc;
      crc = 16'h0000;
      for (int i = 0; i < npre; i++) begin
         rsp_q.push_back(8'hFF); exp_tx.push_back(8'hFF);
      end
      rsp_q.push_back(8'hFE); exp_tx.push_back(8'hFF);
      for (int k = 0; k < BB; k++) begin
         d = (pat == 0) ? 8'(k) : (pat == 1) ? 8'h00 : 8'($urandom);
         rsp_q.push_back(d); exp_tx.push_back(8'hFF);
         exp_wa.push_back(16'(base + k)); exp_wd.push_back(d);
         crc = crc16(crc, d);
      end
`ifndef SPI_BLOCK_DMA_CRC_EN
      if (!crc_force) crc = 16'($urandom);
`endif
      if (crc_force) crc = crc_val;
      rsp_q.push_back(crc[15:8]); rsp_q.push_back(crc[7:0]);
      exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFF);
   endtask

   task automatic add_write_block(input logic [15:0] base, input logic [7:0] resp, input int nbusy);
      logic [7:0]  d;
      logic [15:0] crc;
      crc = 16'h0000;
      rsp_q.push_back(8'($urandom)); exp_tx.push_back(8'hFE);
      for (int k = 0; k < BB; k++) begin
         d = 8'($urandom);
         ram[16'(base + k)] = d;
         rsp_q.push_back(8'($urandom)); exp_tx.push_back(d);
         exp_ra.push_back(16'(base + k));
         crc = crc16(crc, d);
      end
      rsp_q.push_back(8'($urandom)); rsp_q.push_back(8'($urandom));
`ifdef SPI_BLOCK_DMA_CRC_EN
      exp_tx.push_back(crc[15:8]); exp_tx.push_back(crc[7:0]);
`else
      exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFF);
`endif
      rsp_q.push_back(resp); exp_tx.push_back(8'hFF);
      if ((resp & 8'h1F) == 8'h05) begin
         for (int i = 0; i < nbusy; i++) begin
            rsp_q.push_back(8'h00); exp_tx.push_back(8'hFF);
         end
         rsp_q.push_back(8'($urandom_range(1, 255))); exp_tx.push_back(8'hFF);
      end
   endtask

   task automatic do_start(input logic wm, input logic [15:0] a, input logic [3:0] n);
      bit acc;
      acc = 1'b0;
      write_mode = wm; iaddr = a; nblocks = n; start = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ce) begin
            acc = 1'b1;
            break;
         end
      end
      check_eq("start_accept", acc, 1);
      @(posedge clk);
      #2;
      start = 1'b0; iaddr = 16'($urandom); nblocks = 4'($urandom); write_mode = 1'($urandom);
   endtask

   task automatic run_and_check(input string tag, input logic wm, input logic [15:0] a,
                                input logic [3:0] n, input logic exp_err,
                                input logic [3:0] exp_done, input bit poke);
      bit ok;
      int nd;
      tx_log.delete(); wa_log.delete(); wd_log.delete(); ra_log.delete(); viol = 0;
      do_start(wm, a, n);
      @(negedge clk);
      check_eq({tag, ".busy"}, ready, 0);
      if (poke) begin
         start = 1'b1; nblocks = 4'hF; write_mode = ~wm; iaddr = 16'($urandom);
         repeat (3) @(posedge clk);
         #2;
         start = 1'b0;
      end
      ok = 1'b0;
      for (int i = 0; i < 40000; i++) begin
         @(negedge clk);
         if (ready) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq({tag, ".complete"}, ok, 1);
      repeat (4) @(negedge clk);
      check_eq({tag, ".ready"}, ready, 1);
      check_eq({tag, ".error"}, error, exp_err);
      check_eq({tag, ".blocks_done"}, blocks_done, exp_done);
      check_eq({tag, ".tx_len"}, tx_log.size(), exp_tx.size());
      nd = 0;
      for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
         if (tx_log[i] !== exp_tx[i]) nd++;
      check_eq({tag, ".tx_bytes_wrong"}, nd, 0);
      check_eq({tag, ".wr_len"}, wa_log.size(), exp_wa.size());
      nd = 0;
      for (int i = 0; i < exp_wa.size() && i < wa_log.size(); i++)
         if (wa_log[i] !== exp_wa[i] || wd_log[i] !== exp_wd[i]) nd++;
      check_eq({tag, ".wr_wrong"}, nd, 0);
      check_eq({tag, ".rd_len"}, ra_log.size(), exp_ra.size());
      nd = 0;
      for (int i = 0; i < exp_ra.size() && i < ra_log.size(); i++)
         if (ra_log[i] !== exp_ra[i]) nd++;
      check_eq({tag, ".rd_wrong"}, nd, 0);
      check_eq({tag, ".strobe_rules"}, viol, 0);
      $display("CMD %s mode=%0d addr=%04h nblk=%0d ready=%0d error=%0d blocks_done=%0d tx=%0d wr=%0d rd=%0d",
               tag, wm, a, n, ready, error, blocks_done, tx_log.size(), wa_log.size(), ra_log.size());
   endtask

   initial begin
      logic [15:0] a;
      logic [3:0]  n;
      logic        wm;
      bit          ok;
      reset = 1'b1; start = 1'b0; write_mode = 1'b0; iaddr = 16'h0; nblocks = 4'h0;
      ce_rand = 1'b0; busy_max = 2;
      repeat (3) @(negedge clk);
      check_eq("rst.ready", ready, 1);
      check_eq("rst.error", error, 0);
      check_eq("rst.blocks_done", blocks_done, 0);
      check_eq("rst.mem_addr", mem_addr, 0);
      check_eq("rst.spi_do", spi_do, 8'hFF);
      check_eq("rst.strobes", {spi_wr, mem_wr, mem_rd}, 0);
      #2 reset = 1'b0;

      // single block read, counting pattern
      clear_exp();
      add_read_block(16'h0800, 0, 3, 1'b0, 16'h0);
      run_and_check("rd1", 1'b0, 16'h0800, 4'd1, 1'b0, 4'd1, 1'b0);

      // three blocks wrapping past 0xFFFF, gated clock enable
      ce_rand = 1'b1;
      clear_exp();
      for (int b = 0; b < 3; b++) add_read_block(16'(16'hFF00 + b * BB), 2, $urandom_range(0, 4), 1'b0, 16'h0);
      run_and_check("rd3_wrap", 1'b0, 16'hFF00, 4'd3, 1'b0, 4'd3, 1'b0);

      // token timeout: card answers only 0xFF
      ce_rand = 1'b0; busy_max = 0;
      clear_exp();
      for (int i = 0; i < 4096; i++) exp_tx.push_back(8'hFF);
      run_and_check("rd_timeout", 1'b0, 16'h1000, 4'd1, 1'b1, 4'd0, 1'b0);
      busy_max = 2;

      // nblocks = 0 is ignored and leaves the error flag alone
      tx_log.delete();
      write_mode = 1'b0; nblocks = 4'h0; iaddr = 16'h2222; start = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("nblk0.ready", ready, 1);
      check_eq("nblk0.error", error, 1);
      check_eq("nblk0.tx_len", tx_log.size(), 0);

      // two block write, good responses with busy period
      ce_rand = 1'b1;
      clear_exp();
      add_write_block(16'h3000, 8'hE5, 5);
      add_write_block(16'h3200, 8'hE5, 5);
      run_and_check("wr2", 1'b1, 16'h3000, 4'd2, 1'b0, 4'd2, 1'b0);

      // second block rejected
      clear_exp();
      add_write_block(16'h5000, 8'hE5, 2);
      add_write_block(16'h5200, 8'hEB, 0);
      run_and_check("wr2_reject", 1'b1, 16'h5000, 4'd2, 1'b1, 4'd1, 1'b0);

      // reset in the middle of the data phase
      ce_rand = 1'b0;
      clear_exp();
      add_read_block(16'h1234, 2, 1, 1'b0, 16'h0);
      add_read_block(16'h1434, 2, 1, 1'b0, 16'h0);
      wa_log.delete(); wd_log.delete(); tx_log.delete(); ra_log.delete();
      do_start(1'b0, 16'h1234, 4'd2);
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (wa_log.size() >= 100) begin
            ok = 1'b1;
            break;
         end
      end
      check_eq("midrst.reached", ok, 1);
      #2 reset = 1'b1;
      #1;
      check_eq("midrst.strobes", {spi_wr, mem_wr, mem_rd}, 0);
      check_eq("midrst.ready", ready, 1);
      check_eq("midrst.blocks_done", blocks_done, 0);
      check_eq("midrst.mem_addr", mem_addr, 0);
      check_eq("midrst.spi_do", spi_do, 8'hFF);
      repeat (2) @(negedge clk);
      clear_exp();
      #2 reset = 1'b0;
      add_read_block(16'h4000, 2, 2, 1'b0, 16'h0);
      run_and_check("after_reset", 1'b0, 16'h4000, 4'd1, 1'b0, 4'd1, 1'b0);

      // random commands with a spurious start while busy
      ce_rand = 1'b1; busy_max = 1;
      for (int it = 0; it < 3; it++) begin
         wm = 1'($urandom);
         a  = 16'($urandom);
         n  = 4'($urandom_range(1, 2));
         clear_exp();
         for (int b = 0; b < n; b++) begin
            if (wm) add_write_block(16'(a + b * BB), {3'($urandom), 5'h05}, $urandom_range(0, 4));
            else    add_read_block(16'(a + b * BB), 2, $urandom_range(0, 4), 1'b0, 16'h0);
         end
         run_and_check($sformatf("rand%0d", it), wm, a, n, 1'b0, n, 1'b1);
      end

`ifdef SPI_BLOCK_DMA_CRC_EN
      ce_rand = 1'b0;
      clear_exp();
      add_read_block(16'h2000, 1, 1, 1'b1, 16'h0000);
      run_and_check("crc_ok", 1'b0, 16'h2000, 4'd1, 1'b0, 4'd1, 1'b0);
      clear_exp();
      add_read_block(16'h2000, 1, 1, 1'b1, 16'h1234);
      run_and_check("crc_bad", 1'b0, 16'h2000, 4'd1, 1'b1, 4'd0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
